adc_serial_capture: RTL
=======================

Name: adc_serial_capture

Overview:
- Consumes the 32·fs serial clock `s_clk` produced by the team's divider stage and drives a 12-bit serial ADC (AD7476-style: 4 leading zeros, then 12 data bits MSB first).
- Frames one conversion every 32 `s_clk` periods, deserialises it and presents one audio sample per frame to the equaliser datapath with a single-cycle valid strobe.
- Everything runs on the system clock `clk`; `s_clk` is treated as a level signal and edge-detected.

Parameters:
- DATA_W, 12, sample width delivered on `sample`.
- LEAD_ZEROS, 4, leading zero bits the ADC sends before data; DATA_W+LEAD_ZEROS = CONV_LEN.
- CONV_LEN, 16, `s_clk` periods with `adc_cs_n` low.
- FRAME_LEN, 32, total `s_clk` periods per frame; idle length = FRAME_LEN-CONV_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- s_clk  in  1  divided serial clock from the divider stage, same clock domain.
- en  in  1  capture enable.
- adc_sdata  in  1  serial data from the ADC, asynchronous to `clk`.
- adc_sclk  out  1  serial clock to the ADC; combinational pass-through of `s_clk`.
- adc_cs_n  out  1  ADC chip select, active low, registered.
- sample  out  DATA_W  last captured sample, held between frames.
- sample_valid  out  1  one-`clk` pulse when `sample` updates.
- frame_err  out  1  one-`clk` pulse, coincident with `sample_valid`, when any leading bit was 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - `adc_cs_n`=1, `sample`=0, `sample_valid`=0, `frame_err`=0.
  - State=IDLE, bit/edge counters=0, shift register=0, `s_clk_d`=0, synchroniser flops=0.
- Edge detect: `s_clk_d` <= `s_clk` every cycle.
  - rise = `s_clk` & ~`s_clk_d`; fall = ~`s_clk` & `s_clk_d`.
- `adc_sdata` passes through a 2-flop synchroniser (`sd_s`). This is safe because data is stable for half an `s_clk` period, which is at least 3 `clk` cycles.
- IDLE state (`adc_cs_n`=1):
  - Count fall events, 0..FRAME_LEN-CONV_LEN-1.
  - On the fall where count = FRAME_LEN-CONV_LEN-1 and en=1: `adc_cs_n` <= 0, count <= 0, go to CONV.
  - If en=0 at that fall: count holds at its terminal value and the FSM stays in IDLE.
  - When en later returns to 1, CONV starts at the next fall event.
- CONV state (`adc_cs_n`=0):
  - On each rise event, shift `sd_s` into a CONV_LEN-bit shift register, MSB first, and increment the bit count.
  - On the fall event after the CONV_LEN-th rise: `adc_cs_n` <= 1, go to IDLE with fall count <= 0.
  - In that same cycle, register `sample` <= shreg[DATA_W-1:0] and pulse `sample_valid`=1.
  - In that same cycle, `frame_err` = OR of shreg[CONV_LEN-1:DATA_W].
- `en` deasserted during CONV does not abort: the frame completes and delivers its sample.
- Frame period is exactly FRAME_LEN `s_clk` periods. With the divider at /72, `sample_valid` pulses every 2304 `clk` cycles.
- `sample_valid` and `frame_err` are never high for more than one cycle. `sample` changes only in the `sample_valid` cycle.
- Reset mid-CONV: `adc_cs_n` goes high immediately (asynchronously), the partial frame is discarded and no `sample_valid` is produced. After reset release, a full idle period precedes the next conversion.
- Simultaneous rise and fall in one cycle is impossible by construction. If `s_clk` stops, the FSM holds its state indefinitely.

Decomposition:
- Shared package `audio_pkg`: constants DATA_W, CONV_LEN, FRAME_LEN, LEAD_ZEROS; FSM state encoding (IDLE, CONV).
- One natural sub-module: `edge_detect`, which provides the registered delay plus rise/fall pulses. It is reused for `s_clk` here and by the downstream DAC stage.
- The 2-flop synchroniser stays inline.

Test Plan:
1. Hold reset=0 for 10 cycles, then release with en=1 and the /72 `s_clk` running.
   - Required: during reset, `adc_cs_n`=1, `sample`=0 and `sample_valid`=0.
   - Required: the first `adc_cs_n` fall occurs exactly 16 `s_clk` falls after reset release.
2. ADC model shifts 16'h0A5C.
   - Required: `sample`=12'hA5C and `sample_valid` high for exactly 1 cycle.
   - Required: `frame_err`=0 and `adc_cs_n` high for exactly 16 `s_clk` periods afterwards.
3. ADC model shifts 16'h8FFF.
   - Required: `sample`=12'hFFF with `frame_err`=1 coincident with `sample_valid`.
4. Drop en to 0 at the 5th rise of CONV, with the model sending 16'h0123.
   - Required: frame completes with `sample`=12'h123.
   - Required: `adc_cs_n` stays 1 and no `sample_valid` while en=0.
   - Required: the next CONV starts at the first `s_clk` fall after en returns to 1.
5. Pulse reset low at the 8th rise of CONV.
   - Required: `adc_cs_n`=1 within the same cycle, no `sample_valid`, `sample`=0.
6. Run 4 back-to-back frames with values 0x001, 0x7FF, 0x800, 0xFFF.
   - Required: samples appear in order, with `sample_valid` pulses spaced exactly 2304 `clk` cycles apart.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio front end: ADC frame geometry and the
// capture FSM state encoding.
package audio_pkg;

    localparam int DATA_W     = 12;
    localparam int LEAD_ZEROS = 4;
    localparam int CONV_LEN   = DATA_W + LEAD_ZEROS;
    localparam int FRAME_LEN  = 32;
    localparam int IDLE_LEN   = FRAME_LEN - CONV_LEN;

    // One counter serves both phases, so it must reach CONV_LEN.
    localparam int CNT_W = $clog2(CONV_LEN + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // A well-formed frame starts with LEAD_ZEROS zero bits; any 1 there is an error.
    function automatic logic lead_err(input logic [CONV_LEN-1:0] frame);
        return |frame[CONV_LEN-1:DATA_W];
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered one-cycle delay of a level signal plus single-cycle rise/fall
// pulses; shared by the ADC capture and the DAC stage.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    // Delay flop: previous-cycle value of the monitored level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/adc_serial_capture.sv
// Frames and deserialises a 12-bit serial ADC (4 leading zeros + 12 data bits)
// once every FRAME_LEN s_clk periods and presents each sample with a valid strobe.
module adc_serial_capture
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s_clk,
    input  logic              en,
    input  logic              adc_sdata,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LEN - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LEN);

    logic                rise_s;
    logic                fall_s;
    logic                sd_meta_r;
    logic                sd_s;
    logic [0:0]          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CONV_LEN-1:0] shreg_r;

    assign adc_sclk = s_clk;

    edge_detect u_sclk_edge (
        .clk   (clk),
        .reset (reset),
        .din   (s_clk),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Two-flop synchroniser for the ADC data line; data is stable for many clk cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd_meta_r <= 1'b0;
            sd_s      <= 1'b0;
        end else begin
            sd_meta_r <= adc_sdata;
            sd_s      <= sd_meta_r;
        end
    end

    // Frame FSM: cnt_r counts s_clk falls in IDLE and captured bits in CONV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            shreg_r      <= {CONV_LEN{1'b0}};
            adc_cs_n     <= 1'b1;
            sample       <= {DATA_W{1'b0}};
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        if (cnt_r != IDLE_LAST) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else if (en) begin
                            state_r  <= ST_CONV;
                            adc_cs_n <= 1'b0;
                            cnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            // Terminal count holds until capture is re-enabled.
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CONV: begin
                    if (rise_s && (cnt_r != CONV_LAST)) begin
                        shreg_r <= {shreg_r[CONV_LEN-2:0], sd_s};
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end else if (fall_s && (cnt_r == CONV_LAST)) begin
                        // Completing a frame ignores en so a started conversion always delivers.
                        state_r      <= ST_IDLE;
                        adc_cs_n     <= 1'b1;
                        cnt_r        <= {CNT_W{1'b0}};
                        sample       <= shreg_r[DATA_W-1:0];
                        sample_valid <= 1'b1;
                        frame_err    <= lead_err(shreg_r);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    adc_cs_n <= 1'b1;
                    cnt_r    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
